adma_s2mm_framer: RTL
=====================

Name: adma_s2mm_framer

Overview:
- Streaming stage directly upstream of the AXI DMA S2MM slave port of the system block.
- Accepts an unframed sample stream and cuts it into fixed-length frames, asserting tlast on the final beat of each frame.
- Runs a programmed number of frames, or runs continuously until stopped.
- Output is registered through a 2-entry skid buffer, so the DMA sees clean valid/ready timing.

Parameters:
- DATA_WIDTH, 32, stream data width in bits; must be a multiple of 8.
- LEN_WIDTH, 16, width of the frame length in beats.
- CNT_WIDTH, 16, width of the frame count and of the frames-sent counter.

Ports:
- clk  in  1  stream clock.
- rst_n  in  1  reset, asynchronous, active-low.
- s_axis_tdata  in  DATA_WIDTH  input sample data.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  DATA_WIDTH  data to DMA S2MM.
- m_axis_tkeep  out  DATA_WIDTH/8  byte enables; always all ones when valid.
- m_axis_tlast  out  1  last beat of frame.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  DMA ready.
- cfg_frame_len  in  LEN_WIDTH  beats per frame; latched at start.
- cfg_frame_num  in  CNT_WIDTH  frames to run; 0 means continuous; latched at start.
- start  in  1  single-cycle start pulse.
- stop  in  1  single-cycle stop request.
- busy  out  1  framer active or skid buffer not empty.
- done  out  1  single-cycle pulse when the final frame's tlast beat leaves the block.
- cfg_err  out  1  single-cycle pulse when a start is rejected.
- frames_sent  out  CNT_WIDTH  number of output tlast handshakes since the last accepted start.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0. State is IDLE, skid buffer empty, all counters 0, stop_pend 0.
- Reset mid-operation discards buffered beats; no tlast or done is emitted.
- States are IDLE and RUN.
- IDLE:
  - s_axis_tready = 0.
  - On start with cfg_frame_len != 0: latch len and num, clear beat_cnt, frame_cnt, frames_sent and stop_pend, then go to RUN.
  - On start with cfg_frame_len == 0: stay in IDLE and pulse cfg_err on the next cycle.
  - stop in IDLE is ignored. start together with stop in IDLE means start is taken and stop is ignored.
- RUN:
  - s_axis_tready = skid buffer has a free entry.
  - On each input handshake: write {tdata, tlast_i} into the skid buffer, where tlast_i = (beat_cnt == len-1).
  - On each input handshake, beat_cnt increments and wraps to 0 after len-1.
  - On an input handshake with tlast_i = 1: frame_cnt increments.
  - The frame just completed is the last frame if num != 0 and frame_cnt+1 == num, or if stop_pend is set, or if stop is asserted in the same cycle. On the last frame, go to IDLE.
  - stop in RUN sets stop_pend. The current frame always completes, so frames are never truncated. Input keeps being consumed until that frame's last beat.
  - start in RUN is ignored.
  - len == 1: every beat carries tlast.
  - Continuous mode (num == 0): frame_cnt wraps silently. frames_sent wraps modulo 2^CNT_WIDTH.
- Skid buffer / output:
  - Latency from input handshake to m_axis_tvalid is 1 cycle.
  - Full-throughput 1 beat/clk when m_axis_tready is held high.
  - m_axis_tvalid, once high, holds with tdata and tlast stable until m_axis_tready.
  - m_axis_tkeep is all ones whenever m_axis_tvalid is high, else 0.
  - m_axis_tready low with both entries full drops s_axis_tready on the next cycle; no beat is lost or duplicated.
  - Simultaneous write and read when full is not allowed, because ready is computed from the registered free count.
- Status:
  - frames_sent increments on every output handshake with tlast.
  - done pulses 1 cycle after the output tlast handshake of the final frame of a run, whether the run ended by count or by stop.
  - busy = (state == RUN) or skid not empty. busy falls in the same cycle done rises.

Decomposition:
- Package adma_pkg:
  - frm_state_t enum {IDLE, RUN}.
  - Skid entry struct {data, last}.
  - Default width localparams.
- Sub-module axis_skid_buf:
  - 2-entry registered valid/ready buffer, parameterised by payload width.
  - Reused for the DMA MM2S side later.

Test Plan:
- len=4, num=2, m_axis_tready=1, 8 input beats D0..D7 → tlast on D3 and D7, frames_sent=2, done pulses once one cycle after D7 handshake, busy low after.
- len=1, num=3 → three beats each with tlast, fourth input beat not accepted (s_axis_tready=0).
- len=5, num=0, stop asserted at input beat 7 → frame 2 completes with tlast on beat 9, then IDLE; no beat 10 accepted; frames_sent=2, done pulses.
- len=8, num=1, m_axis_tready toggled pseudo-randomly 50% with s_axis_tvalid random → output data equals input order exactly, tvalid/tdata stable while stalled, single tlast on beat 7.
- start with cfg_frame_len=0 → cfg_err pulse, busy stays 0; start in RUN → no effect on counters.
- rst_n asserted mid-frame (beat 2 of len 4) → all outputs 0 immediately; next start begins a fresh frame with tlast on its 4th beat.

Source files
------------

// File: rtl/adma_pkg.sv
// Shared types and default widths for the ADMA stream blocks.
// No logic; latency and backpressure are defined by the modules that import it.
package adma_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 16;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } frm_state_t;

  // Skid entry at default width; parameterised blocks declare their own copy.
  typedef struct packed {
    logic [DATA_W_DEF-1:0] data;
    logic                  last;
  } skid_ent_t;

endpackage

// File: rtl/axis_skid_buf.sv
// 2-entry registered valid/ready buffer, payload-agnostic.
// Latency: write to out_vld 1 cycle; 1 beat/clk sustained when out_rdy is held high.
// Backpressure: in_rdy comes from the registered fill count and drops once both entries are full.
module axis_skid_buf #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   cnt;
  logic         wr;
  logic         rd;

  assign in_rdy  = (cnt != 2'd2);
  assign out_vld = (cnt != 2'd0);
  assign out_dat = mem[rd_ptr];
  assign wr      = in_vld && in_rdy;
  assign rd      = out_vld && out_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (wr) begin
        mem[wr_ptr] <= in_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (rd) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, wr} - {1'b0, rd};
    end
  end

endmodule

// File: rtl/adma_s2mm_framer.sv
// Cuts an unframed sample stream into fixed-length frames for the DMA S2MM port.
// Latency: input handshake to m_axis_tvalid 1 cycle; 1 beat/clk when m_axis_tready is held high.
// Backpressure: s_axis_tready low outside RUN or while the 2-entry output skid is full.
module adma_s2mm_framer
  import adma_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int LEN_WIDTH  = LEN_W_DEF,
  parameter int CNT_WIDTH  = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  input  logic [LEN_WIDTH-1:0]    cfg_frame_len,
  input  logic [CNT_WIDTH-1:0]    cfg_frame_num,
  input  logic                    start,
  input  logic                    stop,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_err,
  output logic [CNT_WIDTH-1:0]    frames_sent
);

  // fin tags the tlast beat of a run's final frame so done fires as it leaves.
  typedef struct packed {
    logic                  fin;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
  } beat_t;

  frm_state_t           state, state_nxt;
  logic [LEN_WIDTH-1:0] len, beat_cnt;
  logic [CNT_WIDTH-1:0] num, frame_cnt;
  logic                 stop_pend;
  logic                 skid_in_rdy;
  logic                 in_hs, out_hs;
  logic                 tlast_i, last_frame, start_ok;
  beat_t                wr_beat, rd_beat;

  assign start_ok      = start && (cfg_frame_len != '0);
  assign s_axis_tready = (state == RUN) && skid_in_rdy;
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign out_hs        = m_axis_tvalid && m_axis_tready;
  assign tlast_i       = (beat_cnt == len - LEN_WIDTH'(1));
  assign last_frame    = tlast_i &&
                         (((num != '0) && (frame_cnt + CNT_WIDTH'(1) == num)) || stop_pend || stop);

  assign wr_beat = '{fin: last_frame, data: s_axis_tdata, last: tlast_i};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (in_hs && last_frame) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      len         <= '0;
      num         <= '0;
      beat_cnt    <= '0;
      frame_cnt   <= '0;
      stop_pend   <= 1'b0;
      frames_sent <= '0;
      done        <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cfg_err <= (state == IDLE) && start && (cfg_frame_len == '0);
      done    <= out_hs && rd_beat.last && rd_beat.fin;
      if ((state == IDLE) && start_ok) begin
        len         <= cfg_frame_len;
        num         <= cfg_frame_num;
        beat_cnt    <= '0;
        frame_cnt   <= '0;
        frames_sent <= '0;
        stop_pend   <= 1'b0;
      end else begin
        if (state == RUN) begin
          if (stop) stop_pend <= 1'b1;
          if (in_hs) begin
            beat_cnt <= tlast_i ? '0 : beat_cnt + LEN_WIDTH'(1);
            if (tlast_i) frame_cnt <= frame_cnt + CNT_WIDTH'(1);
          end
        end
        if (out_hs && rd_beat.last) frames_sent <= frames_sent + CNT_WIDTH'(1);
      end
    end
  end

  axis_skid_buf #(
    .W($bits(beat_t))
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_vld  (in_hs),
    .in_rdy  (skid_in_rdy),
    .in_dat  (wr_beat),
    .out_vld (m_axis_tvalid),
    .out_rdy (m_axis_tready),
    .out_dat (rd_beat)
  );

  assign m_axis_tdata = rd_beat.data;
  assign m_axis_tlast = m_axis_tvalid && rd_beat.last;
  assign m_axis_tkeep = {(DATA_WIDTH/8){m_axis_tvalid}};
  assign busy         = (state == RUN) || m_axis_tvalid;

endmodule
